// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module : serial_subtractor
// Digit-serial two's-complement subtractor, diff = a - b - bin, DIGIT bits
// per clock, with start/busy/done handshake and bout/zero/ovf flags.
// Rev    : 1.0  initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  int               w_base;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_dig;
  logic [DIGIT:0]   w_br;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  always_comb begin
    w_base  = int'(r_cnt) * DIGIT;
    w_a_dig = r_a[w_base +: DIGIT];
    w_b_dig = r_b[w_base +: DIGIT];
  end

  // Full-subtractor cells, borrow rippling through the digit within one cycle.
  assign w_br[0] = r_br;
  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign w_dig[i]  = w_a_dig[i] ^ w_b_dig[i] ^ w_br[i];
      assign w_br[i+1] = (~w_a_dig[i] & (w_b_dig[i] | w_br[i])) | (w_b_dig[i] & w_br[i]);
    end
  endgenerate

  always_comb begin
    w_res = r_res;
    w_res[w_base +: DIGIT] = w_dig;
  end

  assign w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_RUN: begin
          r_res <= w_res;
          r_br  <= w_br[DIGIT];
          r_cnt <= r_cnt + 1'b1;
          // Result flags are published only when the last digit completes.
          if (r_cnt == C_LAST) begin
            diff    <= w_res;
            bout    <= w_br[DIGIT];
            zero    <= (w_res == '0);
            ovf     <= w_ovf;
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_subtractor
// Self-checking bench for serial_subtractor in 8/1, 8/4 and 1/1 configurations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s0, s1, s2;
  logic [7:0] a0, b0, a1, b1;
  logic       a2, b2;
  logic       bi0, bi1, bi2;
  logic       busy0, busy1, busy2, done0, done1, done2;
  logic [7:0] diff0, diff1;
  logic       diff2;
  logic       bo0, bo1, bo2, z0, z1, z2, ov0, ov1, ov2;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(s0), .a(a0), .b(b0), .bin(bi0),
    .busy(busy0), .done(done0), .diff(diff0), .bout(bo0), .zero(z0), .ovf(ov0));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .bin(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bo1), .zero(z1), .ovf(ov1));
  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2), .bin(bi2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bo2), .zero(z2), .ovf(ov2));

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic res_t model(int w, logic [7:0] a, logic [7:0] b, logic bi);
    res_t r;
    int   mask;
    int   d;
    mask   = (1 << w) - 1;
    d      = (int'(a) - int'(b) - int'(bi)) & mask;
    r.diff = 8'(d);
    r.bout = (int'(a) < int'(b) + int'(bi));
    r.zero = (d == 0);
    r.ovf  = (a[w-1] != b[w-1]) && (r.diff[w-1] != a[w-1]);
    return r;
  endfunction

  function automatic int lat_of(int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 2 : 1;
  endfunction

  function automatic int width_of(int sel);
    return (sel == 2) ? 1 : 8;
  endfunction

  function automatic logic get_done(int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction

  function automatic logic get_busy(int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction

  function automatic res_t get_res(int sel);
    res_t r;
    case (sel)
      0:       r = '{diff: diff0, bout: bo0, zero: z0, ovf: ov0};
      1:       r = '{diff: diff1, bout: bo1, zero: z1, ovf: ov1};
      default: r = '{diff: {7'd0, diff2}, bout: bo2, zero: z2, ovf: ov2};
    endcase
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int sel, logic st, logic [7:0] a, logic [7:0] b, logic bi);
    case (sel)
      0:       begin s0 = st; a0 = a; b0 = b; bi0 = bi; end
      1:       begin s1 = st; a1 = a; b1 = b; bi1 = bi; end
      default: begin s2 = st; a2 = a[0]; b2 = b[0]; bi2 = bi; end
    endcase
  endtask

  task automatic check_result(int sel);
    res_t e;
    res_t g;
    if (exp_q.size() == 0) begin
      check($sformatf("sb_empty_%0d", sel), 1, 0);
    end else begin
      e = exp_q.pop_front();
      g = get_res(sel);
      check($sformatf("diff_%0d", sel), g.diff, e.diff);
      check($sformatf("bout_%0d", sel), g.bout, e.bout);
      check($sformatf("zero_%0d", sel), g.zero, e.zero);
      check($sformatf("ovf_%0d", sel),  g.ovf,  e.ovf);
    end
  endtask

  // One isolated operation: latency, busy length, result and single-cycle done.
  task automatic run_op(int sel, logic [7:0] a, logic [7:0] b, logic bi);
    int n;
    int nb;
    @(negedge clk);
    drive(sel, 1'b1, a, b, bi);
    exp_q.push_back(model(width_of(sel), a, b, bi));
    @(negedge clk);
    drive(sel, 1'b0, ~a, ~b, ~bi);
    n  = 0;
    nb = 0;
    while (!get_done(sel) && n < 40) begin
      if (get_busy(sel)) nb++;
      @(negedge clk);
      n++;
    end
    check($sformatf("latency_%0d", sel), n, lat_of(sel));
    check($sformatf("busy_len_%0d", sel), nb, lat_of(sel));
    check_result(sel);
    @(negedge clk);
    check($sformatf("done_pulse_%0d", sel), get_done(sel), 1'b0);
    check($sformatf("idle_busy_%0d", sel), get_busy(sel), 1'b0);
  endtask

  initial begin
    logic [7:0] diff_tbl;
    logic [7:0] bout_tbl;
    logic [7:0] last_diff;
    logic [7:0] ra, rb;
    logic [2:0] abc;
    int         cyc, completions, last_done_cyc, nd;
    res_t       g;

    diff_tbl = 8'b1001_0110;
    bout_tbl = 8'b1000_1110;
    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_busy_%0d", s), get_busy(s), 1'b0);
      check($sformatf("rst_done_%0d", s), get_done(s), 1'b0);
      check($sformatf("rst_res_%0d", s), get_res(s), 11'd0);
    end
    rst = 1'b0;

    run_op(0, 8'h05, 8'h03, 1'b0);
    g = get_res(0);
    check("tp_05_03", {g.diff, g.bout, g.zero, g.ovf}, {8'h02, 3'b000});
    run_op(0, 8'h03, 8'h05, 1'b0);
    g = get_res(0);
    check("tp_03_05", {g.diff, g.bout, g.ovf}, {8'hFE, 2'b10});
    run_op(0, 8'h10, 8'h0F, 1'b1);
    g = get_res(0);
    check("tp_zero", {g.diff, g.bout, g.zero}, {8'h00, 2'b01});
    run_op(0, 8'h7F, 8'h80, 1'b0);

    run_op(1, 8'h00, 8'h00, 1'b1);
    g = get_res(1);
    check("tp_d4_ff", {g.diff, g.bout}, {8'hFF, 1'b1});
    run_op(1, 8'hA5, 8'h3C, 1'b0);
    run_op(1, 8'h12, 8'h12, 1'b0);

    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      run_op(2, {7'd0, abc[2]}, {7'd0, abc[1]}, abc[0]);
      g = get_res(2);
      check($sformatf("fs_diff_%0d", i), g.diff[0], diff_tbl[i]);
      check($sformatf("fs_bout_%0d", i), g.bout, bout_tbl[i]);
    end

    // start held high with inputs changing every cycle; re-accept from DONE.
    last_diff = get_res(0).diff;
    @(negedge clk);
    ra = 8'h9C; rb = 8'h47;
    drive(0, 1'b1, ra, rb, 1'b1);
    exp_q.push_back(model(8, ra, rb, 1'b1));
    cyc = 0; completions = 0; last_done_cyc = 0;
    while (completions < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (done0) begin
        completions++;
        check_result(0);
        if (completions > 1) check("hold_period", cyc - last_done_cyc, 9);
        last_done_cyc = cyc;
        last_diff = diff0;
        if (completions < 3) begin
          drive(0, 1'b1, ra, rb, ra[0]);
          exp_q.push_back(model(8, ra, rb, ra[0]));
        end else begin
          drive(0, 1'b0, ra, rb, 1'b0);
        end
      end else begin
        check("hold_diff_stable", diff0, last_diff);
        drive(0, 1'b1, ra, rb, rb[0]);
      end
    end
    check("hold_completions", completions, 3);
    @(negedge clk);

    run_op(0, 8'h80, 8'h01, 1'b0);
    g = get_res(0);
    check("tp_ovf", {g.diff, g.bout, g.ovf}, {8'h7F, 2'b01});

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    drive(0, 1'b1, 8'h5A, 8'h21, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy0, 1'b0);
    check("midrst_done", done0, 1'b0);
    check("midrst_res", get_res(0), 11'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done0 || busy0) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_op(0, 8'h37, 8'h12, 1'b1);
    g = get_res(0);
    check("post_rst_diff", g.diff, 8'h24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
